// File: rtl/half_sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : half_sigmoid_arbiter
// Purpose  : Round-robin sharing of one pipelined half-precision sigmoid unit
//            among NREQ requesters, with in-order tagged result return.
// Options  : HALF_SIG_ARB_PERF_EN adds perf_issued / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module half_sigmoid_arbiter #(
   parameter int NREQ   = 4,
   parameter int DEPTH  = 8,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   output logic [15:0]          res_data,
   output logic [IDW-1:0]       res_id,
   input  logic                 res_ready,
   output logic                 sig_in_valid,
   output logic [15:0]          sig_a,
   input  logic                 sig_out_valid,
   input  logic [15:0]          sig_c,
   output logic                 err
`ifdef HALF_SIG_ARB_PERF_EN
   ,
   output logic [31:0]          perf_issued,
   output logic [31:0]          perf_stall
`endif
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   logic [IDW-1:0]    r_ptr;
   logic              r_sig_in_valid;
   logic [15:0]       r_sig_a;
   logic              r_err;

   logic [IDW-1:0]    r_tag_mem [DEPTH];
   logic [c_AW-1:0]   r_tag_wr;
   logic [c_AW-1:0]   r_tag_rd;
   logic [c_CW-1:0]   r_tag_count;

   logic [IDW+15:0]   r_res_mem [DEPTH];
   logic [c_AW-1:0]   r_res_wr;
   logic [c_AW-1:0]   r_res_rd;
   logic [c_CW-1:0]   r_res_count;

   logic              w_found;
   logic [IDW-1:0]    w_gnt_id;
   logic [IDW-1:0]    w_idx;
   logic [15:0]       w_gnt_data;
   logic [c_CW:0]     w_outstanding;
   logic              w_credit;
   logic              w_grant;
   logic              w_tag_push;
   logic              w_tag_pop;
   logic              w_res_push;
   logic              w_res_pop;
   logic [IDW+15:0]   w_res_head;

   // Rotating priority: first valid requester strictly after the last winner.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = IDW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx;
         end
      end
   end

   assign w_gnt_data = req_data[{w_gnt_id, 4'b0000} +: 16];

   // A result leaving this cycle already frees its slot for a new grant.
   assign w_outstanding = {1'b0, r_tag_count} + {1'b0, r_res_count}
                        - {{c_CW{1'b0}}, w_res_pop};
   assign w_credit      = w_outstanding < (c_CW+1)'(DEPTH);
   assign w_grant       = w_found && w_credit && !rst;
   assign req_ready     = w_grant ? (NREQ'(1) << w_gnt_id) : '0;

   assign w_tag_push = w_grant;
   assign w_tag_pop  = sig_out_valid && (r_tag_count != '0);
   assign w_res_push = w_tag_pop;
   assign w_res_pop  = res_valid && res_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr          <= IDW'(NREQ - 1);
         r_sig_in_valid <= 1'b0;
         r_sig_a        <= '0;
         r_err          <= 1'b0;
         r_tag_wr       <= '0;
         r_tag_rd       <= '0;
         r_tag_count    <= '0;
         r_res_wr       <= '0;
         r_res_rd       <= '0;
         r_res_count    <= '0;
      end else begin
         r_sig_in_valid <= w_grant;
         if (w_grant) begin
            r_ptr   <= w_gnt_id;
            r_sig_a <= w_gnt_data;
         end
         if (sig_out_valid && (r_tag_count == '0))
            r_err <= 1'b1;
         if (w_tag_push) r_tag_wr <= r_tag_wr + c_AW'(1);
         if (w_tag_pop)  r_tag_rd <= r_tag_rd + c_AW'(1);
         if (w_res_push) r_res_wr <= r_res_wr + c_AW'(1);
         if (w_res_pop)  r_res_rd <= r_res_rd + c_AW'(1);
         case ({w_tag_push, w_tag_pop})
            2'b10:   r_tag_count <= r_tag_count + c_CW'(1);
            2'b01:   r_tag_count <= r_tag_count - c_CW'(1);
            default: ;
         endcase
         case ({w_res_push, w_res_pop})
            2'b10:   r_res_count <= r_res_count + c_CW'(1);
            2'b01:   r_res_count <= r_res_count - c_CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_tag_push) r_tag_mem[r_tag_wr] <= w_gnt_id;
      if (w_res_push) r_res_mem[r_res_wr] <= {r_tag_mem[r_tag_rd], sig_c};
   end

   assign w_res_head   = r_res_mem[r_res_rd];
   assign res_valid    = (r_res_count != '0);
   assign res_data     = res_valid ? w_res_head[15:0] : '0;
   assign res_id       = res_valid ? w_res_head[IDW+15:16] : '0;
   assign sig_in_valid = r_sig_in_valid;
   assign sig_a        = r_sig_a;
   assign err          = r_err;

`ifdef HALF_SIG_ARB_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (r_sig_in_valid && (r_perf_issued != 32'hFFFF_FFFF))
            r_perf_issued <= r_perf_issued + 32'd1;
         if ((|req_valid) && !w_credit && (r_perf_stall != 32'hFFFF_FFFF))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire
